fetch_control_multi: RTL
========================

FETCH_CONTROL_MULTI -- requirements
Module: fetch_control_multi

Interface
REQ-001 Parameter NUM_CH, 3, number of destination RAM channels (1..8).
REQ-002 Parameter SDRAM_AW, 19, SDRAM word-address width.
REQ-003 Parameter RAM_AW, 12, destination RAM address width.
REQ-004 Port i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port i_reset  input  1  asynchronous, active-high reset.
REQ-006 Port i_start  input  1  start request, sampled in IDLE only.
REQ-007 Port i_abort  input  1  abort request, sampled in any non-IDLE state.
REQ-008 Port i_chanEnable  input  NUM_CH  per-channel enable mask, latched at start.
REQ-009 Port i_baseAddr  input  NUM_CH*SDRAM_AW  packed SDRAM base addresses; channel c in bits [c*SDRAM_AW +: SDRAM_AW]; latched at start.
REQ-010 Port i_length  input  RAM_AW+1  words per channel (0..2^RAM_AW), latched at start.
REQ-011 Port i_sdramReady  input  1  one-cycle SDRAM read-data-valid pulse.
REQ-012 Port o_rdSdram  output  1  one-cycle SDRAM read request.
REQ-013 Port o_addrToSdram  output  SDRAM_AW  SDRAM word address, valid while o_rdSdram is high.
REQ-014 Port o_wrRam  output  NUM_CH  one-hot RAM write strobe.
REQ-015 Port o_addrToRam  output  RAM_AW  RAM write address, valid while any o_wrRam bit is high.
REQ-016 Port o_busy  output  1  high in every state except IDLE.
REQ-017 Port o_finish  output  1  one-cycle completion pulse.

Function
REQ-018 The block SHALL use the states IDLE, SELECT, ISSUE, WAIT, WRITE and DONE, and all outputs SHALL be registered.
REQ-019 In IDLE with i_start high, the block SHALL latch the mask, bases and length, set the channel index to 0, clear the word index, and enter SELECT.
REQ-020 In SELECT:
- channel enabled and length nonzero: enter ISSUE;
- otherwise, last channel: enter DONE;
- otherwise: increment the channel index and stay in SELECT (one cycle per skipped channel).
REQ-021 In ISSUE, o_rdSdram SHALL be high for exactly one cycle, o_addrToSdram SHALL equal (base[ch] + word index) modulo 2^SDRAM_AW, and the next state SHALL be WAIT.
REQ-022 In WAIT, the block SHALL hold until i_sdramReady is sampled high, then enter WRITE; there is no timeout.
REQ-023 i_sdramReady outside WAIT SHALL be ignored.
REQ-024 In WRITE, o_wrRam[ch] alone SHALL be high for exactly one cycle, with o_addrToRam equal to the word index truncated to RAM_AW bits.
REQ-025 After WRITE:
- words remain: increment the word index and enter ISSUE;
- channel complete, not last channel: clear the word index, increment the channel, enter SELECT;
- channel complete, last channel: enter DONE.
REQ-026 In DONE, o_finish SHALL be high for one cycle, then the block SHALL return to IDLE.
REQ-027 i_start while o_busy is high SHALL be ignored.
REQ-028 Latched parameters SHALL not change mid-run regardless of input changes.
REQ-029 i_abort high in any non-IDLE state SHALL force IDLE on the next edge: no o_finish, no further strobes, and strobes cleared that cycle.
REQ-030 If i_abort and i_sdramReady are both high in WAIT, abort SHALL win and no write SHALL occur.
REQ-031 An all-zero mask or length 0 SHALL produce o_finish with no reads, NUM_CH+1 cycles after the start edge.
REQ-032 Length 2^RAM_AW SHALL write RAM addresses 0..2^RAM_AW-1 with no early termination.

Reset
REQ-033 While i_reset is high, the block SHALL be in IDLE with o_rdSdram, o_wrRam, o_busy, o_finish, o_addrToSdram, o_addrToRam and all indices at 0, independent of i_clk.
REQ-034 Assertion of i_reset mid-operation SHALL discard the run; the first start after reset SHALL begin a fresh run.

Verification
REQ-035 Bases 0/10000/20000, mask 3'b111, length 4, ready 3 cycles after each request -> reads 0-3, 10000-10003, 20000-20003 in order; each read is followed by a write to RAM0, RAM1 or RAM2 respectively at address 0-3; exactly one o_finish.
REQ-036 Mask 3'b101, same bases -> no read in 10000-10003, no o_wrRam[1]; 8 writes; o_finish once.
REQ-037 Base 524286, length 4, NUM_CH=1 -> SDRAM addresses 524286, 524287, 0, 1; RAM addresses 0-3.
REQ-038 Length 0 -> no o_rdSdram; o_finish NUM_CH+1 cycles after start; o_busy falls afterwards.
REQ-039 i_reset pulsed in WAIT of the second word -> all outputs 0 immediately; an i_start pulse while busy in a later run causes no restart; a new start after reset re-reads from base[0].
REQ-040 i_abort and i_sdramReady both high in the same WAIT cycle -> no o_wrRam pulse, no o_finish, IDLE next cycle.

Source files
------------

// File: rtl/fetch_control_multi.sv
// Multi-channel fetch sequencer: copies a run of SDRAM words into each enabled
// destination RAM, one read/write handshake per word, channel by channel.
module fetch_control_multi #(
    parameter int NUM_CH   = 3,
    parameter int SDRAM_AW = 19,
    parameter int RAM_AW   = 12
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [NUM_CH-1:0]            i_chanEnable,
    input  logic [NUM_CH*SDRAM_AW-1:0]   i_baseAddr,
    input  logic [RAM_AW:0]              i_length,
    input  logic                         i_sdramReady,
    output logic                         o_rdSdram,
    output logic [SDRAM_AW-1:0]          o_addrToSdram,
    output logic [NUM_CH-1:0]            o_wrRam,
    output logic [RAM_AW-1:0]            o_addrToRam,
    output logic                         o_busy,
    output logic                         o_finish
);

    localparam int            CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t                      state, nextState;
    logic [CW-1:0]               chIdx, chNext;
    logic [RAM_AW:0]             wordIdx, wordNext, wordInc;
    logic                        lastCh;
    logic [NUM_CH-1:0]           maskQ;
    logic [NUM_CH*SDRAM_AW-1:0]  baseQ;
    logic [RAM_AW:0]             lenQ;
    logic [SDRAM_AW-1:0]         chBase;

    assign wordInc = wordIdx + 1'b1;
    assign lastCh  = (chIdx == LAST_CH);
    assign chBase  = baseQ[chNext*SDRAM_AW +: SDRAM_AW];

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        nextState = state;
        chNext    = chIdx;
        wordNext  = wordIdx;
        if (state != IDLE && i_abort) begin
            nextState = IDLE;
            chNext    = '0;
            wordNext  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        nextState = SELECT;
                        chNext    = '0;
                        wordNext  = '0;
                    end
                end
                SELECT: begin
                    if (maskQ[chIdx] && lenQ != '0) begin
                        nextState = ISSUE;
                    end else if (lastCh) begin
                        nextState = DONE;
                    end else begin
                        chNext = chIdx + 1'b1;
                    end
                end
                ISSUE: nextState = WAIT;
                WAIT: begin
                    if (i_sdramReady) begin
                        nextState = WRITE;
                    end
                end
                WRITE: begin
                    if (wordInc < lenQ) begin
                        wordNext  = wordInc;
                        nextState = ISSUE;
                    end else if (lastCh) begin
                        nextState = DONE;
                    end else begin
                        wordNext  = '0;
                        chNext    = chIdx + 1'b1;
                        nextState = SELECT;
                    end
                end
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; outputs are
    // decoded from the next state so each registered strobe lines up with its state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            chIdx         <= '0;
            wordIdx       <= '0;
            maskQ         <= '0;
            baseQ         <= '0;
            lenQ          <= '0;
            o_rdSdram     <= 1'b0;
            o_addrToSdram <= '0;
            o_wrRam       <= '0;
            o_addrToRam   <= '0;
            o_busy        <= 1'b0;
            o_finish      <= 1'b0;
        end else begin
            state   <= nextState;
            chIdx   <= chNext;
            wordIdx <= wordNext;
            if (state == IDLE && i_start) begin
                maskQ <= i_chanEnable;
                baseQ <= i_baseAddr;
                lenQ  <= i_length;
            end
            o_rdSdram     <= (nextState == ISSUE);
            o_addrToSdram <= (nextState == ISSUE) ? chBase + SDRAM_AW'(wordNext) : '0;
            o_wrRam       <= (nextState == WRITE) ? (NUM_CH'(1) << chNext) : '0;
            o_addrToRam   <= (nextState == WRITE) ? wordNext[RAM_AW-1:0] : '0;
            o_busy        <= (nextState != IDLE);
            o_finish      <= (nextState == DONE);
        end
    end

endmodule
